ysyx_22041752_wbarb: RTL and testbench

Write-back arbiter and scoreboard for the integer register file. It shares the register file's single write port between two requesters: the in-order pipeline write-back (port A) and the long-latency unit return path for mul/div/load (port B). It also tracks destination registers with outstanding port-B writes so that issue can stall on RAW/WAW hazards. It sits between the execute/memory back-end and the register-file write port (`we`, `addr_w`, `data_w`).

---
 rtl/ysyx_22041752_wbarb.sv | 110 +++++++++++
 tb/tb_ysyx_22041752_wbarb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_wbarb.sv
// ysyx_22041752_wbarb: shares the register-file write port between the
// in-order write-back (port A) and the long-latency return path (port B).
// It also keeps a scoreboard of registers that still have a port-B write outstanding.
// Ports:
//   a_*/b_*         valid/ready write requests (5-bit addr, 64-bit data)
//   set_*           issue marks a register pending a port-B write
//   rd_addr*/busy_r* hazard query for issue-stage sources
//   rf_we/addr/data registered register-file write port
module ysyx_22041752_wbarb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [63:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [63:0] b_data,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [4:0]  set_addr,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        busy_r1,
  output logic        busy_r2,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [63:0] rf_data
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt;
  logic        force_b;
  logic        a_acc;
  logic        b_acc;
  logic        set_acc;
  logic        rf_from_b;
  logic [31:0] busy;
  logic [31:0] busy_nxt;

  // Port B is forced through once it has waited STARVE_MAX cycles.
  assign force_b = (starve_cnt == SMAX);
  assign a_ready = ~(force_b & b_valid);
  assign b_ready = ~a_valid | force_b;
  assign a_acc   = a_valid & a_ready;
  assign b_acc   = b_valid & b_ready;

  assign set_ready = ~busy[set_addr] | (set_addr == 5'd0);
  assign set_acc   = set_valid & set_ready;

  assign busy_r1 = busy[rd_addr1];
  assign busy_r2 = busy[rd_addr2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (b_valid & ~b_ready) begin
      starve_cnt <= force_b ? starve_cnt : starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // rf_addr/rf_data hold when idle; only rf_we drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_addr   <= 5'd0;
      rf_data   <= 64'd0;
      rf_from_b <= 1'b0;
    end else if (a_acc) begin
      rf_we     <= (a_addr != 5'd0);
      rf_addr   <= a_addr;
      rf_data   <= a_data;
      rf_from_b <= 1'b0;
    end else if (b_acc) begin
      rf_we     <= (b_addr != 5'd0);
      rf_addr   <= b_addr;
      rf_data   <= b_data;
      rf_from_b <= 1'b1;
    end else begin
      rf_we     <= 1'b0;
    end
  end

  // A committing port-B write clears its bit; a same-edge set wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_we & rf_from_b) begin
      busy_nxt[rf_addr] = 1'b0;
    end
    if (set_acc) begin
      busy_nxt[set_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_wbarb.sv
// tb_ysyx_22041752_wbarb: directed and random checks of the write-back
// arbiter, with a write scoreboard drained by a monitor process.
module tb_ysyx_22041752_wbarb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, set_addr, rd_addr1, rd_addr2;
  logic [63:0] a_data, b_data;
  logic        set_valid, set_ready, busy_r1, busy_r2;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [63:0] rf_data;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  wr_t         q[$];
  int          vec = 0;
  int          mis = 0;
  logic [63:0] regf [32];

  int          m_cnt;
  bit   [31:0] m_busy;
  bit          m_pwe, m_pb;
  bit   [4:0]  m_paddr;

  ysyx_22041752_wbarb #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .set_valid(set_valid), .set_ready(set_ready), .set_addr(set_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .busy_r1(busy_r1), .busy_r2(busy_r2),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we === 1'b1) regf[rf_addr] <= rf_data;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected one.
  initial forever begin
    @(negedge clk);
    if (rf_we === 1'b1) begin
      if (q.size() == 0) begin
        vec++;
        mis++;
        $display("FAIL rf_unexpected: got write x%0d=%0h expected none",
                 rf_addr, rf_data);
      end else begin
        wr_t w;
        w = q.pop_front();
        chk("rf_addr", 64'(rf_addr), 64'(w.a));
        chk("rf_data", rf_data, w.d);
      end
    end
  end

  task automatic idle();
    a_valid = 0; b_valid = 0; set_valid = 0;
  endtask

  // One clock: check ready/busy against the model at the negedge,
  // advance the model, queue expected writes, return at posedge+1.
  task automatic cyc();
    bit        frc, ear, ebr, esr, aacc, bacc;
    bit [31:0] nb;
    @(negedge clk);
    frc = (m_cnt == 4);
    ear = !(frc && b_valid);
    ebr = !a_valid || frc;
    esr = (set_addr == 0) || !m_busy[set_addr];
    chk("a_ready", 64'(a_ready), 64'(ear));
    chk("b_ready", 64'(b_ready), 64'(ebr));
    chk("set_ready", 64'(set_ready), 64'(esr));
    chk("busy_r1", 64'(busy_r1), 64'(m_busy[rd_addr1]));
    chk("busy_r2", 64'(busy_r2), 64'(m_busy[rd_addr2]));
    chk("mutex", 64'(a_ready & b_ready & a_valid & b_valid), 64'd0);
    aacc = a_valid && ear;
    bacc = b_valid && ebr;
    nb = m_busy;
    if (m_pwe && m_pb) nb[m_paddr] = 1'b0;
    if (set_valid && esr && set_addr != 0) nb[set_addr] = 1'b1;
    m_busy = nb;
    if (b_valid && !ebr) m_cnt = (m_cnt == 4) ? 4 : m_cnt + 1;
    else m_cnt = 0;
    if (aacc) begin
      m_pwe = (a_addr != 0); m_pb = 0; m_paddr = a_addr;
      if (a_addr != 0) q.push_back('{a: a_addr, d: a_data});
    end else if (bacc) begin
      m_pwe = (b_addr != 0); m_pb = 1; m_paddr = b_addr;
      if (b_addr != 0) q.push_back('{a: b_addr, d: b_data});
    end else begin
      m_pwe = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    rst = 1;
    #1;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_addr", 64'(rf_addr), 64'd0);
    chk("rst_rf_data", rf_data, 64'd0);
    q.delete();
    m_cnt = 0; m_busy = '0; m_pwe = 0; m_pb = 0; m_paddr = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    a_addr = 0; a_data = 0; b_addr = 0; b_data = 0;
    set_addr = 0; rd_addr1 = 0; rd_addr2 = 0;
    m_cnt = 0; m_busy = '0; m_pwe = 0; m_pb = 0; m_paddr = 0;
    @(posedge clk);
    #1;
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_a_ready", 64'(a_ready), 64'd1);
    chk("reset_set_ready", 64'(set_ready), 64'd1);
    rst = 0;

    // Reset while a write is registered but not committed.
    a_valid = 1; a_addr = 3; a_data = 64'h55;
    cyc();
    a_valid = 0;
    chk("pre_rst_we", 64'(rf_we), 64'd1);
    mid_reset();
    a_valid = 1; a_addr = 5; a_data = 64'h1234;
    cyc();
    a_valid = 0;
    chk("post_rst_we", 64'(rf_we), 64'd1);
    chk("post_rst_addr", 64'(rf_addr), 64'd5);
    chk("post_rst_data", rf_data, 64'h1234);
    cyc();

    // Starvation: B forced through every fifth cycle.
    for (int i = 0; i < 15; i++) begin
      a_valid = 1; a_addr = 5'(i + 1); a_data = 64'(i);
      b_valid = 1; b_addr = 5'd20; b_data = 64'(100 + i);
      #1;
      chk("starve_b_ready", 64'(b_ready), 64'(i % 5 == 4));
      chk("starve_a_ready", 64'(a_ready), 64'(i % 5 != 4));
      cyc();
    end
    idle();
    cyc();

    // Scoreboard round trip on x7.
    set_valid = 1; set_addr = 7; rd_addr1 = 7;
    cyc();
    set_valid = 0;
    #1;
    chk("rt_busy_c1", 64'(busy_r1), 64'd1);
    cyc();
    cyc();
    b_valid = 1; b_addr = 7; b_data = 64'hDEAD;
    cyc();
    b_valid = 0;
    chk("rt_we_c4", 64'(rf_we), 64'd1);
    chk("rt_busy_c4", 64'(busy_r1), 64'd1);
    cyc();
    chk("rt_busy_c5", 64'(busy_r1), 64'd0);
    chk("rt_regfile", regf[7], 64'hDEAD);

    // WAW on x9.
    set_valid = 1; set_addr = 9;
    cyc();
    #1;
    chk("waw_stall", 64'(set_ready), 64'd0);
    cyc();
    set_valid = 0;
    b_valid = 1; b_addr = 9; b_data = 64'h99;
    cyc();
    b_valid = 0;
    set_valid = 1; set_addr = 9;
    #1;
    chk("waw_commit_stall", 64'(set_ready), 64'd0);
    cyc();
    #1;
    chk("waw_reset_ok", 64'(set_ready), 64'd1);
    cyc();
    set_valid = 0; rd_addr2 = 9;
    #1;
    chk("waw_rebusy", 64'(busy_r2), 64'd1);
    b_valid = 1; b_addr = 9; b_data = 64'h9A;
    cyc();
    idle();
    cyc();
    cyc();

    // x0 handling.
    a_valid = 1; a_addr = 0; a_data = 64'h77;
    #1;
    chk("x0_a_ready", 64'(a_ready), 64'd1);
    cyc();
    a_valid = 0;
    chk("x0_a_we", 64'(rf_we), 64'd0);
    b_valid = 1; b_addr = 0; b_data = 64'h78;
    #1;
    chk("x0_b_ready", 64'(b_ready), 64'd1);
    cyc();
    b_valid = 0;
    chk("x0_b_we", 64'(rf_we), 64'd0);
    set_valid = 1; set_addr = 0;
    #1;
    chk("x0_set_ready", 64'(set_ready), 64'd1);
    cyc();
    set_valid = 0; rd_addr1 = 0;
    #1;
    chk("x0_busy", 64'(busy_r1), 64'd0);
    cyc();

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      a_valid = 1'($urandom);
      b_valid = 1'($urandom);
      set_valid = 1'($urandom);
      a_addr = 5'($urandom); b_addr = 5'($urandom);
      set_addr = 5'($urandom);
      rd_addr1 = 5'($urandom); rd_addr2 = 5'($urandom);
      a_data = {$urandom, $urandom};
      b_data = {$urandom, $urandom};
      cyc();
    end
    idle();
    for (int r = 0; r < 32; r++) begin
      rd_addr1 = 5'(r);
      #1;
      chk("busy_vec", 64'(busy_r1), 64'(m_busy[r]));
    end
    cyc();
    cyc();
    cyc();
    chk("sb_drain", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
